// File: rtl/ram_programmer.sv
// UART loader: after a magic byte string, takes a LE word count and LE data words and strobes them out.
// Word strobe one cycle after its 4th byte's receive strobe; no backpressure, the UART line sets the pace.
module ram_programmer #(
    parameter int                      CLK_FREQ     = 50_000_000,
    parameter int                      BAUD_RATE    = 115200,
    parameter int                      SEQ_LENGTH   = 8,
    parameter logic [8*SEQ_LENGTH-1:0] MAGIC_SEQ    = "CERESTST",
    parameter int                      BREAK_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_rx_i,
    output logic [31:0] prog_addr_o,
    output logic [31:0] prog_data_o,
    output logic        prog_valid_o,
    output logic        prog_mode_o,
    output logic        system_reset_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int MW           = $clog2(SEQ_LENGTH + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_DATA} state_t;

    rx_state_t   rx_state_q, rx_state_d;
    state_t      state_q, state_d;
    logic        rx_meta, rx_sync, rx_prev;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        byte_vld;
    logic        rx_tick;

    logic [MW-1:0] match_idx;
    logic [1:0]    byte_cnt;
    logic [31:0]   shift_q, word_count, word_idx, idle_cnt;
    logic [31:0]   asm_word;
    logic          idle_timeout, magic_hit;

    function automatic logic [7:0] magic_byte(input int idx);
        return MAGIC_SEQ[8*(SEQ_LENGTH-idx)-1 -: 8];
    endfunction

    // The start-bit check runs for half a bit so later samples land mid-bit.
    assign rx_tick = (rx_state_q == RX_START) ? (rx_cnt == 32'(HALF_BIT - 1))
                                              : (rx_cnt == 32'(CLKS_PER_BIT - 1));

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_d = RX_START;
            RX_START: if (rx_tick) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (rx_tick) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_vld   <= 1'b0;
        end else begin
            rx_meta    <= uart_rx_i;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state_q <= rx_state_d;
            byte_vld   <= 1'b0;
            if (rx_state_q == RX_IDLE || rx_tick) rx_cnt <= '0;
            else                                  rx_cnt <= rx_cnt + 32'd1;
            if (rx_state_q != RX_DATA) begin
                rx_bit <= '0;
            end else if (rx_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            // A low stop bit drops the byte silently.
            if (rx_state_q == RX_STOP && rx_tick && rx_sync) byte_vld <= 1'b1;
        end
    end

    assign asm_word     = {rx_shift, shift_q[31:8]};
    assign idle_timeout = idle_cnt >= 32'(BREAK_CYCLES);
    assign magic_hit    = rx_shift == magic_byte(int'(match_idx));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (byte_vld && magic_hit && match_idx == MW'(SEQ_LENGTH - 1)) state_d = ST_COUNT;
            ST_COUNT:
                if (idle_timeout)                         state_d = ST_IDLE;
                else if (byte_vld && byte_cnt == 2'd3)    state_d = (asm_word == '0) ? ST_IDLE : ST_DATA;
            ST_DATA:
                // word_idx has already advanced past the word being strobed
                if (idle_timeout || (prog_valid_o && word_idx == word_count)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign prog_mode_o    = state_q != ST_IDLE;
    assign system_reset_o = state_q != ST_IDLE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            match_idx    <= '0;
            byte_cnt     <= '0;
            shift_q      <= '0;
            word_count   <= '0;
            word_idx     <= '0;
            idle_cnt     <= '0;
            prog_addr_o  <= '0;
            prog_data_o  <= '0;
            prog_valid_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_valid_o <= 1'b0;
            if (state_q == ST_IDLE) begin
                byte_cnt <= '0;
                idle_cnt <= '0;
                word_idx <= '0;
                if (byte_vld) begin
                    if (magic_hit)
                        match_idx <= (match_idx == MW'(SEQ_LENGTH - 1)) ? '0 : match_idx + MW'(1);
                    else
                        match_idx <= (rx_shift == magic_byte(0)) ? MW'(1) : '0;
                end
            end else begin
                match_idx <= '0;
                idle_cnt  <= byte_vld ? '0 : idle_cnt + 32'd1;
                if (byte_vld && !idle_timeout) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    shift_q  <= asm_word;
                    if (byte_cnt == 2'd3) begin
                        if (state_q == ST_COUNT) begin
                            word_count <= asm_word;
                            word_idx   <= '0;
                        end else begin
                            prog_data_o  <= asm_word;
                            prog_addr_o  <= word_idx;
                            prog_valid_o <= 1'b1;
                            word_idx     <= word_idx + 32'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_programmer.sv
// Directed bench for ram_programmer: bit-banged UART frames in, observed word strobes checked against hand values.
module tb_ram_programmer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] prog_addr, prog_data;
    logic        prog_valid, prog_mode, sys_rst;

    ram_programmer #(
        .CLK_FREQ(100), .BAUD_RATE(10), .SEQ_LENGTH(2), .MAGIC_SEQ("AB"), .BREAK_CYCLES(500)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(rx),
        .prog_addr_o(prog_addr), .prog_data_o(prog_data), .prog_valid_o(prog_valid),
        .prog_mode_o(prog_mode), .system_reset_o(sys_rst)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] s_addr[$];
    logic [31:0] s_data[$];
    int   rises = 0, v_out = 0, mode_diff = 0;
    logic mode_prev = 1'b0;

    always @(negedge clk) begin
        if (prog_valid === 1'b1) begin
            s_addr.push_back(prog_addr);
            s_data.push_back(prog_data);
            if (prog_mode !== 1'b1) v_out++;
        end
        if (prog_mode !== sys_rst) mode_diff++;
        if (prog_mode === 1'b1 && !mode_prev) rises++;
        mode_prev = (prog_mode === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) @(negedge clk);
        end
        rx = stop_bit;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        if (!stop_bit) repeat (20) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic clear_q;
        s_addr.delete();
        s_data.delete();
    endtask

    int r0;

    initial begin
        idle(5);
        chk_eq("rst_addr",  prog_addr,  32'h0);
        chk_eq("rst_data",  prog_data,  32'h0);
        chk_eq("rst_valid", prog_valid, 32'h0);
        chk_eq("rst_mode",  prog_mode,  32'h0);
        chk_eq("rst_sysrst", sys_rst,   32'h0);
        rst_n = 1'b1;
        idle(5);

        // Two-word session
        clear_q();
        send_byte(8'h41);
        idle(2);
        chk_eq("t1_mode_after_A", prog_mode, 32'h0);
        send_byte(8'h42);
        idle(2);
        chk_eq("t1_mode_after_B", prog_mode, 32'h1);
        chk_eq("t1_sysrst_after_B", sys_rst, 32'h1);
        send_word(32'h0000_0002);
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        idle(3);
        chk_eq("t1_strobes", s_addr.size(), 32'd2);
        if (s_addr.size() >= 2) begin
            chk_eq("t1_addr0", s_addr[0], 32'h0);
            chk_eq("t1_data0", s_data[0], 32'h1234_5678);
            chk_eq("t1_addr1", s_addr[1], 32'h1);
            chk_eq("t1_data1", s_data[1], 32'hDEAD_BEEF);
        end
        chk_eq("t1_mode_end", prog_mode, 32'h0);
        chk_eq("t1_addr_hold", prog_addr, 32'h1);
        chk_eq("t1_data_hold", prog_data, 32'hDEAD_BEEF);

        // "AAB" restarts on byte 0; zero count ends the session with no strobe
        clear_q();
        r0 = rises;
        send_byte(8'h41); send_byte(8'h41); send_byte(8'h42);
        idle(2);
        chk_eq("t2_aab_mode", prog_mode, 32'h1);
        send_word(32'h0);
        idle(3);
        chk_eq("t2_zero_mode", prog_mode, 32'h0);
        chk_eq("t2_rises", rises - r0, 32'd1);
        chk_eq("t2_strobes", s_addr.size(), 32'd0);

        r0 = rises;
        send_byte(8'h41); send_byte(8'h58); send_byte(8'h42);
        idle(2);
        chk_eq("t3_axb_mode", prog_mode, 32'h0);
        chk_eq("t3_axb_rises", rises - r0, 32'd0);

        // Inter-byte timeout with a half-built word
        clear_q();
        send_byte(8'h41); send_byte(8'h42);
        send_word(32'h0000_0001);
        send_byte(8'h11); send_byte(8'h22);
        idle(480);
        chk_eq("t4_mode_before_timeout", prog_mode, 32'h1);
        idle(50);
        chk_eq("t4_mode_after_timeout", prog_mode, 32'h0);
        chk_eq("t4_strobes", s_addr.size(), 32'd0);

        // Framing error and one-clock glitch are both invisible to the matcher
        send_byte(8'h41);
        send_byte(8'h42, 1'b0);
        idle(2);
        chk_eq("t5_bad_stop_mode", prog_mode, 32'h0);
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        idle(30);
        send_byte(8'h42);
        idle(2);
        chk_eq("t5_resume_mode", prog_mode, 32'h1);
        send_word(32'h0);
        idle(3);
        chk_eq("t5_end_mode", prog_mode, 32'h0);

        // Reset in the middle of a data word
        clear_q();
        send_byte(8'h41); send_byte(8'h42);
        send_word(32'h0000_0001);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk_eq("t6_mode_pre_reset", prog_mode, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_mode",   prog_mode,  32'h0);
        chk_eq("t6_rst_sysrst", sys_rst,    32'h0);
        chk_eq("t6_rst_valid",  prog_valid, 32'h0);
        chk_eq("t6_rst_addr",   prog_addr,  32'h0);
        chk_eq("t6_rst_data",   prog_data,  32'h0);
        idle(5);
        rst_n = 1'b1;
        idle(5);
        send_byte(8'h41); send_byte(8'h42);
        send_word(32'h0000_0001);
        send_word(32'h1122_3344);
        idle(3);
        chk_eq("t6_strobes", s_addr.size(), 32'd1);
        if (s_addr.size() >= 1) begin
            chk_eq("t6_addr0", s_addr[0], 32'h0);
            chk_eq("t6_data0", s_data[0], 32'h1122_3344);
        end
        chk_eq("t6_mode_end", prog_mode, 32'h0);

        chk_eq("valid_outside_mode", v_out, 32'd0);
        chk_eq("mode_vs_sysrst", mode_diff, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
